// File: rtl/eh2_bp_ghr_ckpt.sv
// Speculative GHR tracker with per-prediction history checkpoints and mispredict/flush recovery.
// Optional checkpoint parity protection is enabled by defining RV_GHR_CKPT_PARITY_EN.
module eh2_bp_ghr_ckpt #(
    parameter int GHR_SIZE = 8,
    parameter int DEPTH    = 8,
    parameter int TAG_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pred_valid,
    input  logic                pred_taken,
    output logic                pred_ready,
    output logic [TAG_W-1:0]    pred_tag,
    input  logic                ret_valid,
    input  logic                ret_taken,
    input  logic                mp_valid,
    input  logic [TAG_W-1:0]    mp_tag,
    input  logic                mp_taken,
    input  logic                flush,
    output logic [GHR_SIZE-1:0] ghr,
    output logic [GHR_SIZE-1:0] arch_ghr,
    output logic                ckpt_perr
);

    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

    logic [GHR_SIZE-1:0] ckpt [DEPTH];
    logic [TAG_W-1:0]    wr_ptr, rd_ptr;
    logic [TAG_W:0]      count;

    logic                ret_do, accept, mp_hit, mp_do, perr_hit;
    logic [TAG_W-1:0]    rd_next, mp_off, mp_next;
    logic [TAG_W:0]      ret_amt;
    logic [GHR_SIZE-1:0] arch_next, mp_src;

    assign pred_ready = !rst && (count != FULL) && !mp_valid && !flush;
    assign pred_tag   = wr_ptr;

    // Offset of the mispredicted tag from the oldest entry decides whether it is in flight.
    always_comb begin
        ret_do    = ret_valid && (count != '0);
        ret_amt   = (TAG_W+1)'(ret_do);
        rd_next   = rd_ptr + TAG_W'(ret_do);
        arch_next = ret_do ? {arch_ghr[GHR_SIZE-2:0], ret_taken} : arch_ghr;
        mp_off    = mp_tag - rd_ptr;
        mp_next   = mp_tag + TAG_W'(1);
        mp_hit    = mp_valid && ({1'b0, mp_off} < count);
        mp_do     = mp_hit && !flush;
        accept    = pred_valid && pred_ready;
        mp_src    = perr_hit ? arch_next : ckpt[mp_tag];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr      <= '0;
            arch_ghr <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            rd_ptr   <= rd_next;
            arch_ghr <= arch_next;
            if (flush) begin
                ghr    <= arch_next;
                wr_ptr <= rd_next;
                count  <= '0;
            end else if (mp_do) begin
                ghr    <= {mp_src[GHR_SIZE-2:0], mp_taken};
                wr_ptr <= mp_next;
                count  <= {1'b0, mp_off} + (TAG_W+1)'(1) - ret_amt;
            end else if (accept) begin
                ghr    <= {ghr[GHR_SIZE-2:0], pred_taken};
                wr_ptr <= wr_ptr + TAG_W'(1);
                count  <= count + (TAG_W+1)'(1) - ret_amt;
            end else begin
                count  <= count - ret_amt;
            end
        end
    end

`ifdef RV_GHR_CKPT_PARITY_EN
    logic ckpt_par [DEPTH];

    assign perr_hit = mp_do && ((^ckpt[mp_tag]) != ckpt_par[mp_tag]);

    // Contents are cleared on reset so that stale parity never reports an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ckpt[i]     <= '0;
                ckpt_par[i] <= 1'b0;
            end
        end else if (accept) begin
            ckpt[wr_ptr]     <= ghr;
            ckpt_par[wr_ptr] <= ^ghr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ckpt_perr <= 1'b0;
        end else begin
            ckpt_perr <= perr_hit;
        end
    end
`else
    assign perr_hit  = 1'b0;
    assign ckpt_perr = 1'b0;

    always_ff @(posedge clk) begin
        if (accept) begin
            ckpt[wr_ptr] <= ghr;
        end
    end
`endif

    a_ret_nonempty: assert property (@(posedge clk) disable iff (rst)
        ret_valid |-> (count != '0));
    a_mp_in_flight: assert property (@(posedge clk) disable iff (rst)
        (mp_valid && !flush) |-> mp_hit);

endmodule

// File: tb/tb_eh2_bp_ghr_ckpt.sv
// Self-checking bench for eh2_bp_ghr_ckpt: directed vector table, hand sequences, and
// randomized traffic against a queue-based model of the in-flight checkpoints.
module tb_eh2_bp_ghr_ckpt;

    localparam int G = 8;
    localparam int D = 8;
    localparam int M = (1 << G) - 1;

    logic       clk = 1'b0;
    logic       rst, pred_valid, pred_taken, ret_valid, ret_taken, mp_valid, mp_taken, flush;
    logic [2:0] mp_tag;
    logic       pred_ready, ckpt_perr;
    logic [2:0] pred_tag;
    logic [7:0] ghr, arch_ghr;

    int checks   = 0;
    int failures = 0;

    // Model: queue of pre-update histories, oldest first; head tag tracked separately.
    int mghr, march, mrd;
    int q[$];

    typedef struct {
        bit pv, pt, rv, rt, mv;
        int mtag;
        bit mt, fl, rs;
        int eghr, earch;
        bit erdy;
        int etag;
    } vec_t;

    vec_t tbl[$];

    eh2_bp_ghr_ckpt #(.GHR_SIZE(G), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_ready(pred_ready), .pred_tag(pred_tag),
        .ret_valid(ret_valid), .ret_taken(ret_taken),
        .mp_valid(mp_valid), .mp_tag(mp_tag), .mp_taken(mp_taken),
        .flush(flush), .ghr(ghr), .arch_ghr(arch_ghr), .ckpt_perr(ckpt_perr)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit pv, bit pt, bit rv, bit rt, bit mv, int mtag, bit mt, bit fl,
                                int eghr, int earch, bit erdy, int etag);
        vec_t v;
        v.pv = pv; v.pt = pt; v.rv = rv; v.rt = rt; v.mv = mv; v.mtag = mtag; v.mt = mt;
        v.fl = fl; v.rs = 1'b0; v.eghr = eghr; v.earch = earch; v.erdy = erdy; v.etag = etag;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic bit modelReady(input vec_t v);
        return !v.rs && (q.size() != D) && !v.mv && !v.fl;
    endfunction

    task automatic modelStep(input vec_t v);
        int  idx, arch_n;
        bit  retire, rdy;
        if (v.rs) begin
            q.delete();
            mghr = 0; march = 0; mrd = 0;
            return;
        end
        rdy    = modelReady(v);
        retire = v.rv && (q.size() > 0);
        arch_n = retire ? (((march << 1) | int'(v.rt)) & M) : march;
        if (v.fl) begin
            mghr = arch_n;
            q.delete();
            if (retire) mrd = (mrd + 1) % D;
        end else begin
            if (v.mv) begin
                idx = (v.mtag - mrd + D) % D;
                if (idx < q.size()) begin
                    mghr = ((q[idx] << 1) | int'(v.mt)) & M;
                    while (q.size() > idx + 1) void'(q.pop_back());
                end
            end else if (v.pv && rdy) begin
                q.push_back(mghr);
                mghr = ((mghr << 1) | int'(v.pt)) & M;
            end
            if (retire) begin
                void'(q.pop_front());
                mrd = (mrd + 1) % D;
            end
        end
        march = arch_n;
    endtask

    task automatic applyStimulus(input vec_t v, output bit rdy, output int tag);
        pred_valid = v.pv; pred_taken = v.pt; ret_valid = v.rv; ret_taken = v.rt;
        mp_valid = v.mv; mp_tag = 3'(v.mtag); mp_taken = v.mt; flush = v.fl; rst = v.rs;
        #1;
        rdy = pred_ready;
        tag = int'(pred_tag);
        checkOutput("pred_ready", int'(pred_ready), int'(modelReady(v)));
        if (!v.rs) checkOutput("pred_tag", int'(pred_tag), (mrd + q.size()) % D);
        @(posedge clk);
        modelStep(v);
        #1;
        checkOutput("ghr", int'(ghr), mghr);
        checkOutput("arch_ghr", int'(arch_ghr), march);
        checkOutput("ckpt_perr", int'(ckpt_perr), 0);
    endtask

    task automatic doReset();
        vec_t v;
        bit   r;
        int   t;
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.rs = 1'b1;
        applyStimulus(v, r, t);
        applyStimulus(v, r, t);
        checkOutput("rst_ready", int'(r), 0);
    endtask

    initial begin
        vec_t v;
        bit   r;
        int   t;
        bit   mp_done;

        pred_valid = 0; pred_taken = 0; ret_valid = 0; ret_taken = 0;
        mp_valid = 0; mp_tag = 0; mp_taken = 0; flush = 0; rst = 1;
        mghr = 0; march = 0; mrd = 0;

        // Directed table: pv pt rv rt mv mtag mt fl | ghr arch ready tag
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 'h01, 'h00, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 'h02, 'h00, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 'h05, 'h00, 1, 2));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 'h0B, 'h00, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 'h03, 'h00, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h03, 'h00, 1, 2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 'h03, 'h01, 1, 2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 'h03, 'h03, 1, 2));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 'h07, 'h03, 1, 2));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 'h0F, 'h03, 1, 3));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 'h1F, 'h03, 1, 4));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 'h06, 'h06, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h06, 'h06, 1, 3));

        doReset();
        checkOutput("reset_ghr", int'(ghr), 0);
        checkOutput("reset_arch", int'(arch_ghr), 0);
        checkOutput("reset_tag", int'(pred_tag), 0);
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i], r, t);
            checkOutput($sformatf("tbl%0d_ready", i), int'(r), int'(tbl[i].erdy));
            checkOutput($sformatf("tbl%0d_tag", i), t, tbl[i].etag);
            checkOutput($sformatf("tbl%0d_ghr", i), int'(ghr), tbl[i].eghr);
            checkOutput($sformatf("tbl%0d_arch", i), int'(arch_ghr), tbl[i].earch);
        end

        // Fill to full, then a rejected prediction and a retire that frees space a cycle later.
        doReset();
        for (int i = 0; i < D; i++) applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), r, t);
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), r, t);
        checkOutput("full_ready", int'(r), 0);
        checkOutput("full_ghr", int'(ghr), 'hFF);
        checkOutput("full_tag", int'(pred_tag), 0);
        applyStimulus(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), r, t);
        checkOutput("full_ret_ready", int'(r), 0);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), r, t);
        checkOutput("after_ret_ready", int'(r), 1);

        // Wrap: steady predict/retire pairs, one mispredict at tag 7 once tags have wrapped.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), r, t);
        mp_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (!mp_done && ((mrd + q.size()) % D == 1)) begin
                applyStimulus(mk(0, 0, 1, 1, 1, 7, 1, 0, 0, 0, 0, 0), r, t);
                mp_done = 1;
            end else begin
                applyStimulus(mk(1, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)),
                                 0, 0, 0, 0, 0, 0, 0, 0), r, t);
            end
        end
        checkOutput("wrap_mp_seen", int'(mp_done), 1);

`ifdef RV_GHR_CKPT_PARITY_EN
        doReset();
        applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), r, t);
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), r, t);
        applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), r, t);
        applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), r, t);
        applyStimulus(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), r, t);
        dut.ckpt[2][0] = ~dut.ckpt[2][0];
        pred_valid = 0; ret_valid = 0; flush = 0;
        mp_valid = 1; mp_tag = 3'd2; mp_taken = 0;
        @(posedge clk);
        #1;
        mp_valid = 0;
        checkOutput("perr_ghr", int'(ghr), 'h02);
        checkOutput("perr_pulse", int'(ckpt_perr), 1);
        @(posedge clk);
        #1;
        checkOutput("perr_clear", int'(ckpt_perr), 0);
`endif

        // Randomized traffic, including occasional mid-operation reset.
        doReset();
        for (int i = 0; i < 600; i++) begin
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.pv = ($urandom_range(0, 3) != 0);
            v.pt = 1'($urandom_range(0, 1));
            v.rt = 1'($urandom_range(0, 1));
            v.mt = 1'($urandom_range(0, 1));
            if (q.size() > 0) begin
                v.rv = 1'($urandom_range(0, 1));
                v.mv = ($urandom_range(0, 5) == 0);
                v.mtag = (mrd + $urandom_range(0, q.size() - 1)) % D;
            end
            v.fl = ($urandom_range(0, 15) == 0);
            v.rs = ($urandom_range(0, 63) == 0);
            applyStimulus(v, r, t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
